// File: rtl/axis_fifo_controller.sv
// axis_fifo_controller
//
// Command-port initiator for the AXI-stream FIFO. Each request on the req stream
// is expanded into a micro-sequence of FIFO Set/Get commands. The status replies
// are collected and one packed snapshot, including the computed fill level, is
// returned on the rsp stream.
//
// Ports:
//   aclk, areset                  clock, synchronous active-high reset
//   req_tvalid/tready/tdata       request: [1:0] op, [PosWidth+1:2] arg
//                                 op 0 Snapshot, 1 SetEnable, 2 Flush, 3 Resize
//   rsp_tvalid/tready/tdata       response: {error, full, en_out, en_in,
//                                 length_1, rd, wr, level[PosWidth:0]}
//   cmd_tvalid/tready/tdata       FIFO command: {data, code[3:0]}
//   status_tvalid/tready/tdata    FIFO status reply
module axis_fifo_controller #(
    parameter int unsigned PosWidth      = 3,
    parameter int unsigned CmdDataWidth  = (PosWidth > 2) ? PosWidth : 2,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic                      aclk,
    input  logic                      areset,

    input  logic                      req_tvalid,
    output logic                      req_tready,
    input  logic [PosWidth+1:0]       req_tdata,

    output logic                      rsp_tvalid,
    input  logic                      rsp_tready,
    output logic [4*PosWidth+4:0]     rsp_tdata,

    output logic                      cmd_tvalid,
    input  logic                      cmd_tready,
    output logic [CmdDataWidth+3:0]   cmd_tdata,

    input  logic                      status_tvalid,
    output logic                      status_tready,
    input  logic [CmdDataWidth-1:0]   status_tdata
);

    localparam logic [1:0] OpSnapshot  = 2'd0;
    localparam logic [1:0] OpSetEnable = 2'd1;
    localparam logic [1:0] OpFlush     = 2'd2;
    localparam logic [1:0] OpResize    = 2'd3;

    localparam logic [3:0] CodeSetEnIO  = 4'd0;
    localparam logic [3:0] CodeSetWr    = 4'd1;
    localparam logic [3:0] CodeSetRd    = 4'd2;
    localparam logic [3:0] CodeSetFull  = 4'd3;
    localparam logic [3:0] CodeSetLen   = 4'd4;
    localparam logic [3:0] CodeGetEnIO  = 4'd5;
    localparam logic [3:0] CodeGetWr    = 4'd6;
    localparam logic [3:0] CodeGetRd    = 4'd7;
    localparam logic [3:0] CodeGetFull  = 4'd8;
    localparam logic [3:0] CodeGetLen   = 4'd9;

    localparam int unsigned TmoW   = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
    localparam logic [TmoW-1:0] TmoMax =
        TmoW'((TimeoutCycles == 0) ? 0 : TimeoutCycles - 1);
    localparam bit TmoEn = (TimeoutCycles != 0);

    localparam int unsigned RspW = 4 * PosWidth + 5;
    localparam logic [RspW-1:0] RspError = {1'b1, {(RspW-1){1'b0}}};
    localparam logic [PosWidth:0] LvlOne = (PosWidth+1)'(1);

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StCalc, StResp} state_e;

    state_e                  state_q;
    logic [3:0]              step_q;
    logic [1:0]              op_q;
    logic [PosWidth-1:0]     arg_q;
    logic [1:0]              en_q;
    logic [PosWidth-1:0]     wr_q;
    logic [PosWidth-1:0]     rd_q;
    logic [PosWidth-1:0]     len1_q;
    logic                    full_q;
    logic [TmoW-1:0]         tmo_q;

    logic [3:0]              cur_code;
    logic                    cur_is_get;
    logic                    tmo_hit;
    logic [CmdDataWidth+3:0] next_cmd;
    logic [PosWidth:0]       len_full;
    logic [PosWidth:0]       wr_ext;
    logic [PosWidth:0]       rd_ext;
    logic [PosWidth:0]       level;

    // Command for a given step of an op's micro-sequence. Every op ends with the
    // five-step snapshot GetEnIO..GetLen, whose codes are consecutive.
    function automatic logic [CmdDataWidth+3:0] step_cmd(
        input logic [1:0]          op,
        input logic [3:0]          step,
        input logic [PosWidth-1:0] arg,
        input logic [1:0]          en
    );
        logic [3:0]              code;
        logic [CmdDataWidth-1:0] data;
        logic                    snap;
        logic [3:0]              idx;
        code = CodeGetEnIO;
        data = '0;
        snap = 1'b0;
        idx  = step;
        unique case (op)
            OpSnapshot: snap = 1'b1;
            OpSetEnable: begin
                if (step == 4'd0) begin
                    code = CodeSetEnIO;
                    data = CmdDataWidth'(arg[1:0]);
                end else begin
                    snap = 1'b1;
                    idx  = step - 4'd1;
                end
            end
            OpFlush: begin
                case (step)
                    4'd0: code = CodeGetEnIO;
                    4'd1: code = CodeSetEnIO;
                    4'd2: code = CodeSetWr;
                    4'd3: code = CodeSetRd;
                    4'd4: code = CodeSetFull;
                    4'd5: begin
                        code = CodeSetEnIO;
                        data = CmdDataWidth'(en);
                    end
                    default: begin
                        snap = 1'b1;
                        idx  = step - 4'd6;
                    end
                endcase
            end
            OpResize: begin
                case (step)
                    4'd0: code = CodeGetEnIO;
                    4'd1: code = CodeSetEnIO;
                    4'd2: begin
                        code = CodeSetLen;
                        data = CmdDataWidth'(arg);
                    end
                    4'd3: code = CodeSetWr;
                    4'd4: code = CodeSetRd;
                    4'd5: code = CodeSetFull;
                    4'd6: begin
                        code = CodeSetEnIO;
                        data = CmdDataWidth'(en);
                    end
                    default: begin
                        snap = 1'b1;
                        idx  = step - 4'd7;
                    end
                endcase
            end
        endcase
        if (snap) begin
            code = CodeGetEnIO + idx;
        end
        return {data, code};
    endfunction

    always_comb begin
        cur_code   = cmd_tdata[3:0];
        cur_is_get = (cur_code >= CodeGetEnIO);
        tmo_hit    = TmoEn && (tmo_q == TmoMax);
        next_cmd   = step_cmd(op_q, step_q + 4'd1, arg_q, en_q);
    end

    // Fill level from the captured pointers; L is length_1+1 at PosWidth+1 bits.
    always_comb begin
        len_full = {1'b0, len1_q} + LvlOne;
        wr_ext   = {1'b0, wr_q};
        rd_ext   = {1'b0, rd_q};
        if (full_q) begin
            level = len_full;
        end else if (wr_q >= rd_q) begin
            level = wr_ext - rd_ext;
        end else begin
            level = wr_ext + len_full - rd_ext;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q       <= StIdle;
            step_q        <= '0;
            op_q          <= '0;
            arg_q         <= '0;
            en_q          <= '0;
            wr_q          <= '0;
            rd_q          <= '0;
            len1_q        <= '0;
            full_q        <= 1'b0;
            tmo_q         <= '0;
            req_tready    <= 1'b0;
            cmd_tvalid    <= 1'b0;
            cmd_tdata     <= '0;
            status_tready <= 1'b1;
            rsp_tvalid    <= 1'b0;
            rsp_tdata     <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    req_tready <= 1'b1;
                    if (req_tvalid && req_tready) begin
                        op_q          <= req_tdata[1:0];
                        arg_q         <= req_tdata[PosWidth+1:2];
                        step_q        <= '0;
                        tmo_q         <= '0;
                        cmd_tdata     <= step_cmd(req_tdata[1:0], 4'd0,
                                                  req_tdata[PosWidth+1:2], en_q);
                        cmd_tvalid    <= 1'b1;
                        status_tready <= 1'b0;
                        req_tready    <= 1'b0;
                        state_q       <= StIssue;
                    end
                end

                StIssue: begin
                    if (cmd_tready) begin
                        tmo_q <= '0;
                        if (cur_is_get) begin
                            cmd_tvalid    <= 1'b0;
                            status_tready <= 1'b1;
                            state_q       <= StWait;
                        end else begin
                            // Set commands chain straight into the next step.
                            step_q    <= step_q + 4'd1;
                            cmd_tdata <= next_cmd;
                        end
                    end else if (tmo_hit) begin
                        cmd_tvalid    <= 1'b0;
                        status_tready <= 1'b1;
                        rsp_tdata     <= RspError;
                        rsp_tvalid    <= 1'b1;
                        state_q       <= StResp;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end

                StWait: begin
                    if (status_tvalid) begin
                        tmo_q <= '0;
                        // Upper status bits are stale for EnIO and Full replies.
                        case (cur_code)
                            CodeGetEnIO: en_q   <= status_tdata[1:0];
                            CodeGetWr:   wr_q   <= status_tdata[PosWidth-1:0];
                            CodeGetRd:   rd_q   <= status_tdata[PosWidth-1:0];
                            CodeGetFull: full_q <= status_tdata[0];
                            CodeGetLen:  len1_q <= status_tdata[PosWidth-1:0];
                            default: ;
                        endcase
                        if (cur_code == CodeGetLen) begin
                            state_q <= StCalc;
                        end else begin
                            step_q        <= step_q + 4'd1;
                            cmd_tdata     <= next_cmd;
                            cmd_tvalid    <= 1'b1;
                            status_tready <= 1'b0;
                            state_q       <= StIssue;
                        end
                    end else if (tmo_hit) begin
                        rsp_tdata  <= RspError;
                        rsp_tvalid <= 1'b1;
                        state_q    <= StResp;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end

                StCalc: begin
                    rsp_tdata  <= {1'b0, full_q, en_q, len1_q, rd_q, wr_q, level};
                    rsp_tvalid <= 1'b1;
                    state_q    <= StResp;
                end

                StResp: begin
                    if (rsp_tready) begin
                        rsp_tvalid <= 1'b0;
                        req_tready <= 1'b1;
                        state_q    <= StIdle;
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/axis_fifo_controller.md
# axis_fifo_controller

Command-port initiator for the AXI-stream FIFO. It accepts high-level maintenance requests (snapshot, set enables, flush, resize) on a request stream and expands each one into a sequence of FIFO Set/Get commands. It collects the FIFO's status replies and returns one packed snapshot, including the computed fill level, per request. It sits between a host/register bridge and the FIFO's `cmd_*`/`status_*` ports.

## Interface
Parameters:
- `PosWidth`, 3: width of FIFO position pointers; must equal the FIFO's pointer width.
- `CmdDataWidth`, max(PosWidth,2): command/status data width.
- `TimeoutCycles`, 255: cycles allowed per handshake wait; 0 disables the timeout.

Ports:
- `aclk`  in  1  clock. One clock; reset is synchronous and active-high.
- `areset`  in  1  synchronous active-high reset.
- `req_tvalid`/`req_tready`  in/out  1  request handshake.
- `req_tdata`  in  PosWidth+2  [1:0] op (0 Snapshot, 1 SetEnable, 2 Flush, 3 Resize); [PosWidth+1:2] arg.
- `rsp_tvalid`/`rsp_tready`  out/in  1  response handshake.
- `rsp_tdata`  out  4*PosWidth+5  {error, fullFlag, enableOutput, enableInput, length_1, rdPos, wrPos, level[PosWidth:0]}, with level in the LSBs.
- `cmd_tvalid`/`cmd_tready`  out/in  1  FIFO command handshake.
- `cmd_tdata`  out  CmdDataWidth+4  {data, code[3:0]}. Codes: SetEnIO 0, SetWr 1, SetRd 2, SetFull 3, SetLen 4, GetEnIO 5, GetWr 6, GetRd 7, GetFull 8, GetLen 9.
- `status_tvalid`/`status_tready`  in/out  1  FIFO status handshake.
- `status_tdata`  in  CmdDataWidth  FIFO status reply.

## Operation
- FSM states: IDLE, ISSUE, WAIT, CALC, RESP. A step counter indexes a per-op micro-sequence.
- IDLE: `req_tready`=1. A request handshake latches op/arg and moves to ISSUE at step 0.
- ISSUE: `cmd_tvalid`=1 with the step's command. On `cmd_tready`, a Set command advances to the next step in ISSUE; a Get command moves to WAIT.
- WAIT: on `status_tvalid`, capture the field and go to the next step (ISSUE), or to CALC after GetLen.
- Capture rules: EnIO uses `status_tdata[1:0]` and FullFlag uses `[0]`; upper bits are ignored because the FIFO leaves them stale.
- `status_tready`=1 in every state except ISSUE. A beat received outside WAIT is discarded.
- Micro-sequences. S denotes the snapshot = GetEnIO, GetWr, GetRd, GetFull, GetLen.
  - Snapshot: S.
  - SetEnable: SetEnIO(arg[1:0]), then S.
  - Flush: GetEnIO (saved), SetEnIO(0), SetWr(0), SetRd(0), SetFull(0), SetEnIO(saved), then S.
  - Resize: same as Flush, with SetLen(arg) inserted after SetEnIO(0).
- Fill level, computed in CALC, with L = length_1+1 at PosWidth+1 bits:
  - full → L;
  - wr≥rd → wr−rd;
  - otherwise wr+L−rd.
- RESP: `rsp_tvalid`=1, and `rsp_tdata` is held stable until `rsp_tready`; then return to IDLE.
- Timeout: a counter resets on entry to ISSUE/WAIT and increments each stalled cycle. When it reaches TimeoutCycles, the remaining sequence is aborted and the FSM goes to RESP with error=1 and all other fields 0.
- Reset (including mid-operation): go to IDLE; the in-flight op is dropped with no response and no further commands.

## Timing
- Reset values: `req_tready`=0 during reset and 1 in the first cycle after; `cmd_tvalid`=0, `rsp_tvalid`=0, `status_tready`=1, `cmd_tdata`=0, `rsp_tdata`=0.
- Reference timing assumes a FIFO with `cmd_tready`=1 and status one cycle after the command, with the request accepted at cycle 0:
  - Set command: 1 cycle.
  - Get command: 2 cycles (ISSUE, WAIT).
  - CALC: 1 cycle.
- Resulting `rsp_tvalid` cycles:
  - Snapshot: cycle 12.
  - SetEnable: cycle 13.
  - Flush: cycle 19.
  - Resize: cycle 20.
- Exactly one command is outstanding at a time, and no new request is accepted until the response handshake completes.
- `cmd_tdata` is stable while `cmd_tvalid`=1 and `cmd_tready`=0.

## Test plan
- Snapshot with FIFO length 8, wr=2, rd=6, not full → rsp fields wr 2, rd 6, length_1 7, level 4, error 0, rsp_tvalid at cycle 12.
- Push 8 words, then Snapshot → fullFlag 1, wr=rd=0, level 8.
- Flush on a FIFO holding 5 words with enables 11 → command codes 5,0,1,2,3,0,5,6,7,8,9 in order; final level 0, enables 11; `o_tvalid` stays 0 afterwards.
- Resize arg=3 → SetLen data 3 is issued; rsp length_1 3, level 0, rsp at cycle 20. Then write 4 words → full, level 4.
- Hold `status_tvalid`=0 with TimeoutCycles=4 → rsp with error=1 and all other fields 0 after 4 stalled WAIT cycles. A late status beat arriving afterwards is discarded, and the next Snapshot is correct.
- `areset` asserted during step 3 of Flush → no further cmd beats, `rsp_tvalid`=0, `req_tready`=1 in the cycle after reset is released. Also: `rsp_tready`=0 for 5 cycles → `rsp_tdata` stays stable and `req_tready` stays 0.
